// File: rtl/m_timer_pkg.sv
// Shared types and limits for the MM:SS countdown timer.
// The state encoding is visible on the top-level state_dbg port.
package m_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SEC_H_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
  } mmss_t;

  function automatic logic bcd_le(input logic [3:0] d, input logic [3:0] lim);
    return (d <= lim);
  endfunction

endpackage

// File: rtl/m_bcd_dec_digit.sv
// One BCD digit decrementer. When the digit is 0 it wraps to WRAP and asserts a borrow
// into the next, more significant digit.
module m_bcd_dec_digit
  import m_timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX
) (
  input  logic [3:0] digit_i,
  input  logic       dec_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (dec_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = WRAP;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/m_countdown_mmss.sv
// MM:SS countdown timer: BCD digit load with validation, a one-second prescaler and
// a four-state control FSM. All pulse outputs are registered and last one clock cycle.
module m_countdown_mmss
  import m_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_MAX  = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ld_min_h,
  input  logic [3:0] ld_min_l,
  input  logic [3:0] ld_sec_h,
  input  logic [3:0] ld_sec_l,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       sec_borrow,
  output logic       load_err,
  output logic [1:0] state_dbg
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      MM_H       = 4'(MIN_MAX / 10);
  localparam logic [3:0]      MM_L       = 4'(MIN_MAX % 10);

  state_e        state_q, state_d;
  mmss_t         val_q, val_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          borrow_q, borrow_d;
  logic          lerr_q, lerr_d;

  logic  ld_ok, ld_take, ld_rej;
  logic  value_nz, in_run, run_cnt, tick;
  logic  pause_take, start_take, hit_zero;
  mmss_t dec_val;
  logic  b_sec_l, b_sec_h, b_min_l, b_min_h;

  // Minutes are range-checked digit-wise against MIN_MAX so no binary value is formed.
  always_comb begin
    ld_ok = bcd_le(ld_min_h, BCD_MAX) && bcd_le(ld_min_l, BCD_MAX) &&
            bcd_le(ld_sec_h, SEC_H_MAX) && bcd_le(ld_sec_l, BCD_MAX) &&
            ((ld_min_h < MM_H) || ((ld_min_h == MM_H) && (ld_min_l <= MM_L)));
  end

  assign ld_take    = load && ld_ok;
  assign ld_rej     = load && !ld_ok;
  assign value_nz   = |val_q;
  assign in_run     = (state_q == ST_RUN);
  // load owns the cycle, then pause; start in RUN is ignored so it never blocks a tick.
  assign run_cnt    = !load && !pause && in_run;
  assign tick       = run_cnt && (presc_q == PRESC_LAST);
  assign pause_take = !load && pause && in_run;
  assign start_take = !load && !pause && start && value_nz &&
                      ((state_q == ST_IDLE) || (state_q == ST_PAUSE));

  m_bcd_dec_digit #(.WRAP(BCD_MAX)) u_dec_sec_l (
    .digit_i (val_q.sec_l),
    .dec_i   (tick),
    .digit_o (dec_val.sec_l),
    .borrow_o(b_sec_l)
  );

  m_bcd_dec_digit #(.WRAP(SEC_H_MAX)) u_dec_sec_h (
    .digit_i (val_q.sec_h),
    .dec_i   (b_sec_l),
    .digit_o (dec_val.sec_h),
    .borrow_o(b_sec_h)
  );

  m_bcd_dec_digit #(.WRAP(BCD_MAX)) u_dec_min_l (
    .digit_i (val_q.min_l),
    .dec_i   (b_sec_h),
    .digit_o (dec_val.min_l),
    .borrow_o(b_min_l)
  );

  // A borrow out of min_h would mean decrementing 00:00, which RUN never does.
  m_bcd_dec_digit #(.WRAP(BCD_MAX)) u_dec_min_h (
    .digit_i (val_q.min_h),
    .dec_i   (b_min_l),
    .digit_o (dec_val.min_h),
    .borrow_o(b_min_h)
  );

  assign hit_zero = tick && (dec_val == '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (ld_take) begin
      state_d = ST_IDLE;
    end else if (ld_rej) begin
      state_d = state_q;
    end else if (pause_take) begin
      state_d = ST_PAUSE;
    end else if (start_take) begin
      state_d = ST_RUN;
    end else if (hit_zero) begin
      state_d = ST_EXPIRED;
    end
  end

  // FSM outputs
  always_comb begin
    running   = (state_q == ST_RUN);
    expired   = (state_q == ST_EXPIRED);
    state_dbg = state_q;
  end

  // Datapath next values
  always_comb begin
    val_d    = val_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    borrow_d = 1'b0;
    lerr_d   = ld_rej;
    if (ld_take) begin
      val_d   = '{min_h: ld_min_h, min_l: ld_min_l, sec_h: ld_sec_h, sec_l: ld_sec_l};
      presc_d = '0;
    end else if (run_cnt) begin
      if (tick) begin
        val_d    = dec_val;
        presc_d  = '0;
        done_d   = hit_zero;
        borrow_d = b_sec_h;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      val_q    <= val_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      lerr_q   <= lerr_d;
    end
  end

  assign min_h      = val_q.min_h;
  assign min_l      = val_q.min_l;
  assign sec_h      = val_q.sec_h;
  assign sec_l      = val_q.sec_l;
  assign done       = done_q;
  assign sec_borrow = borrow_q;
  assign load_err   = lerr_q;

  logic unused_ok;
  assign unused_ok = b_min_h;

endmodule
